// File: rtl/sw_array_feeder.sv
// sw_array_feeder: serialises query bases into a shadow buffer, commits the
// full query in parallel to a systolic array and streams target bases to it
// with a single registered cycle of latency and one bubble between targets.
module sw_array_feeder #(
    parameter int NUM_PES = 1000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [1:0]                         q_base_in,
    input  logic                               q_valid_in,
    input  logic                               q_last_in,
    output logic                               q_ready_out,
    input  logic [1:0]                         t_base_in,
    input  logic                               t_valid_in,
    input  logic                               t_last_in,
    output logic                               t_ready_out,
    output logic [NUM_PES*2-1:0]               S_out,
    output logic [1:0]                         T_out,
    output logic                               store_S_out,
    output logic                               init_out,
    output logic [$clog2(NUM_PES+1)-1:0]       q_len_out,
    output logic                               underrun_err_out
);

    localparam int CW = $clog2(NUM_PES + 1);
    localparam logic [CW-1:0] NP_C      = CW'(NUM_PES);
    localparam logic [CW-1:0] HOLD_INIT = CW'(NUM_PES - 1);
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    typedef enum logic [1:0] {IDLE, STREAM, BUBBLE} state_t;

    state_t                 state_q, state_d;
    logic [NUM_PES*2-1:0]   sh_reg_q, sh_reg_d;
    logic [CW-1:0]          sh_cnt_q, sh_cnt_d;
    logic                   sh_full_q, sh_full_d;
    logic [NUM_PES*2-1:0]   s_q, s_d;
    logic [CW-1:0]          q_len_q, q_len_d;
    logic [CW-1:0]          hold_q, hold_d;
    logic                   committed_q, committed_d;
    logic [1:0]             t_q, t_d;
    logic                   init_q, init_d;
    logic                   store_q, store_d;
    logic                   underrun_q, underrun_d;
    logic                   t_rdy;
    logic                   commit;
    logic                   q_fire;

    // Target FSM: readiness from state only, registered array-side outputs
    always_comb begin
        state_d    = state_q;
        t_rdy      = 1'b0;
        t_d        = 2'b00;
        init_d     = 1'b0;
        store_d    = 1'b0;
        commit     = 1'b0;
        underrun_d = underrun_q;
        case (state_q)
            IDLE: begin
                // A fresh query must wait for the store_S ripple of the last
                // commit to finish; an old query may be reused at any time.
                t_rdy = sh_full_q ? (hold_q == '0) : committed_q;
                if (t_valid_in && t_rdy) begin
                    t_d     = t_base_in;
                    init_d  = 1'b1;
                    store_d = sh_full_q;
                    commit  = sh_full_q;
                    state_d = t_last_in ? BUBBLE : STREAM;
                end
            end
            STREAM: begin
                t_rdy = 1'b1;
                if (t_valid_in) begin
                    t_d = t_base_in;
                    if (t_last_in) state_d = BUBBLE;
                end else begin
                    underrun_d = 1'b1;
                end
            end
            BUBBLE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shadow query buffer, commit into S_out and store_S hold counter
    always_comb begin
        sh_reg_d    = sh_reg_q;
        sh_cnt_d    = sh_cnt_q;
        sh_full_d   = sh_full_q;
        s_d         = s_q;
        q_len_d     = q_len_q;
        committed_d = committed_q;
        hold_d      = (hold_q != '0) ? hold_q - ONE_C : hold_q;
        q_fire      = q_valid_in && !sh_full_q;
        if (commit) begin
            s_d         = sh_reg_q;
            q_len_d     = sh_cnt_q;
            hold_d      = HOLD_INIT;
            committed_d = 1'b1;
            sh_reg_d    = '0;
            sh_cnt_d    = '0;
            sh_full_d   = 1'b0;
        end
        if (q_fire) begin
            for (int i = 0; i < NUM_PES; i++) begin
                if (sh_cnt_d == CW'(i)) sh_reg_d[2*i +: 2] = q_base_in;
            end
            sh_cnt_d = sh_cnt_d + ONE_C;
            if (q_last_in || (sh_cnt_d == NP_C)) sh_full_d = 1'b1;
        end
    end

    // State registers with synchronous reset overriding any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_reg_q    <= '0;
            sh_cnt_q    <= '0;
            sh_full_q   <= 1'b0;
            s_q         <= '0;
            q_len_q     <= '0;
            hold_q      <= '0;
            committed_q <= 1'b0;
            t_q         <= 2'b00;
            init_q      <= 1'b0;
            store_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_reg_q    <= sh_reg_d;
            sh_cnt_q    <= sh_cnt_d;
            sh_full_q   <= sh_full_d;
            s_q         <= s_d;
            q_len_q     <= q_len_d;
            hold_q      <= hold_d;
            committed_q <= committed_d;
            t_q         <= t_d;
            init_q      <= init_d;
            store_q     <= store_d;
            underrun_q  <= underrun_d;
        end
    end

    assign q_ready_out      = !sh_full_q;
    assign t_ready_out      = t_rdy;
    assign S_out            = s_q;
    assign q_len_out        = q_len_q;
    assign T_out            = t_q;
    assign init_out         = init_q;
    assign store_S_out      = store_q;
    assign underrun_err_out = underrun_q;

endmodule

// File: tb/tb_sw_array_feeder.sv
// Directed bench for sw_array_feeder with NUM_PES=4.
module tb_sw_array_feeder;

    localparam int NP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] q_base;
    logic       q_valid, q_last, q_ready;
    logic [1:0] t_base;
    logic       t_valid, t_last, t_ready;
    logic [NP*2-1:0] s_out;
    logic [1:0] t_out;
    logic       store_s, init_o;
    logic [$clog2(NP+1)-1:0] q_len;
    logic       underrun;

    int checks   = 0;
    int failures = 0;

    sw_array_feeder #(.NUM_PES(NP)) dut (
        .clk(clk), .rst(rst),
        .q_base_in(q_base), .q_valid_in(q_valid), .q_last_in(q_last), .q_ready_out(q_ready),
        .t_base_in(t_base), .t_valid_in(t_valid), .t_last_in(t_last), .t_ready_out(t_ready),
        .S_out(s_out), .T_out(t_out), .store_S_out(store_s), .init_out(init_o),
        .q_len_out(q_len), .underrun_err_out(underrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; q_base = 0; q_valid = 0; q_last = 0;
        t_base = 0; t_valid = 0; t_last = 0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        chk("rst_q_ready", q_ready, 1);
        chk("rst_t_ready", t_ready, 0);
        chk("rst_s_out", s_out, 0);
        chk("rst_t_out", t_out, 0);
        chk("rst_init", init_o, 0);
        chk("rst_store", store_s, 0);
        chk("rst_qlen", q_len, 0);
        chk("rst_underrun", underrun, 0);

        // query 1,2,3,0 with last on the 4th beat
        q_valid = 1; q_base = 1; q_last = 0;
        chk("q1_ready_b0", q_ready, 1);
        step(); q_base = 2;
        step(); q_base = 3;
        step(); q_base = 0; q_last = 1;
        step(); q_valid = 0; q_last = 0;
        chk("q1_ready_low", q_ready, 0);
        chk("q1_t_ready", t_ready, 1);
        chk("q1_t_idle", t_out, 0);

        // target 2,1
        t_valid = 1; t_base = 2; t_last = 0;
        step();
        chk("t1b0_T", t_out, 2);
        chk("t1b0_init", init_o, 1);
        chk("t1b0_store", store_s, 1);
        chk("t1b0_S", s_out, 8'b00111001);
        chk("t1b0_qlen", q_len, 4);
        chk("t1b0_q_ready", q_ready, 1);
        chk("t1b0_t_ready", t_ready, 1);
        chk("t1b0_underrun", underrun, 0);
        t_base = 1; t_last = 1;
        step();
        chk("t1b1_T", t_out, 1);
        chk("t1b1_init", init_o, 0);
        chk("t1b1_store", store_s, 0);
        chk("t1b1_t_ready", t_ready, 0);
        // back-to-back second target, single beat, held valid through bubble
        t_base = 3; t_last = 1;
        step();
        chk("bub1_T", t_out, 0);
        chk("bub1_init", init_o, 0);
        chk("bub1_store", store_s, 0);
        chk("bub1_t_ready", t_ready, 1);
        step();
        chk("t2_T", t_out, 3);
        chk("t2_init", init_o, 1);
        chk("t2_store", store_s, 0);
        chk("t2_S", s_out, 8'b00111001);
        chk("t2_qlen", q_len, 4);
        t_valid = 0; t_last = 0;
        step();
        chk("bub2_T", t_out, 0);
        chk("bub2_init", init_o, 0);

        // short query 3,3
        q_valid = 1; q_base = 3; q_last = 0;
        step(); q_last = 1;
        step(); q_valid = 0; q_last = 0;
        chk("q2_ready_low", q_ready, 0);
        chk("q2_t_ready", t_ready, 1);
        t_valid = 1; t_base = 2; t_last = 0;
        step();
        chk("t3b0_T", t_out, 2);
        chk("t3b0_store", store_s, 1);
        chk("t3b0_S", s_out, 8'b00001111);
        chk("t3b0_qlen", q_len, 2);
        chk("t3b0_q_ready", q_ready, 1);
        // single-beat query loaded concurrently with the target's last beat
        q_valid = 1; q_base = 2; q_last = 1;
        t_base = 1; t_last = 1;
        step();
        q_valid = 0; q_last = 0; t_valid = 0; t_last = 0;
        chk("t3b1_q_ready", q_ready, 0);
        chk("t3b1_T", t_out, 1);
        chk("t3b1_S", s_out, 8'b00001111);
        step();
        chk("hold_t_ready_low", t_ready, 0);
        chk("hold_bub_T", t_out, 0);
        t_valid = 1; t_base = 2; t_last = 1;
        step();
        chk("hold_wait_T", t_out, 0);
        chk("hold_wait_S", s_out, 8'b00001111);
        chk("hold_done_t_ready", t_ready, 1);
        step();
        chk("t4_T", t_out, 2);
        chk("t4_init", init_o, 1);
        chk("t4_store", store_s, 1);
        chk("t4_S", s_out, 8'b00000010);
        chk("t4_qlen", q_len, 1);

        // query 0,1,2,3 filled by count, no last
        t_valid = 0; t_last = 0;
        q_valid = 1; q_base = 0; q_last = 0;
        step(); q_base = 1;
        step(); q_base = 2;
        step(); q_base = 3;
        step(); q_valid = 0;
        chk("q3_ready_low", q_ready, 0);
        chk("q3_t_ready", t_ready, 1);
        chk("q3_S_held", s_out, 8'b00000010);

        // target with an underrun cycle
        t_valid = 1; t_base = 1; t_last = 0;
        step();
        chk("t5b0_T", t_out, 1);
        chk("t5b0_store", store_s, 1);
        chk("t5b0_S", s_out, 8'b11100100);
        chk("t5b0_qlen", q_len, 4);
        chk("t5b0_underrun", underrun, 0);
        t_valid = 0;
        step();
        chk("under_flag", underrun, 1);
        chk("under_T", t_out, 0);
        chk("under_init", init_o, 0);
        t_valid = 1; t_base = 3; t_last = 1;
        step();
        chk("t5b1_T", t_out, 3);
        chk("t5b1_underrun", underrun, 1);
        chk("t5b1_init", init_o, 0);
        t_valid = 0; t_last = 0;
        step();
        chk("bub5_T", t_out, 0);
        chk("bub5_underrun", underrun, 1);
        chk("bub5_t_ready", t_ready, 1);

        // reset during STREAM
        t_valid = 1; t_base = 2; t_last = 0;
        step();
        chk("t6_T", t_out, 2);
        chk("t6_init", init_o, 1);
        chk("t6_store", store_s, 0);
        rst = 1;
        step();
        rst = 0;
        chk("rs_T", t_out, 0);
        chk("rs_init", init_o, 0);
        chk("rs_store", store_s, 0);
        chk("rs_S", s_out, 0);
        chk("rs_qlen", q_len, 0);
        chk("rs_underrun", underrun, 0);
        chk("rs_t_ready", t_ready, 0);
        chk("rs_q_ready", q_ready, 1);
        step();
        chk("post_rs_T", t_out, 0);
        chk("post_rs_t_ready", t_ready, 0);
        t_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sw_array_feeder.md
SW_ARRAY_FEEDER -- requirements
Module: sw_array_feeder

Interface
REQ-001 The block SHALL have parameter NUM_PES, default 1000, meaning the number of PEs in the downstream parallel-load systolic array.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 Ports q_base_in [1:0], q_valid_in, q_last_in (inputs) and q_ready_out (output): serial query-base stream, valid/ready handshake, last marks the final base.
REQ-005 Ports t_base_in [1:0], t_valid_in, t_last_in (inputs) and t_ready_out (output): serial target-base stream, valid/ready handshake.
REQ-006 Port S_out, output, [NUM_PES*2-1:0]: committed query; bits [2i+1:2i] feed PE i.
REQ-007 Ports T_out [1:0], store_S_out and init_out, outputs: the array's T_in, store_S_in and init_in.
REQ-008 Port q_len_out, output, [$clog2(NUM_PES+1)-1:0]: base count of the committed query.
REQ-009 Port underrun_err_out, output, 1 bit: sticky target-underrun flag.

Function
REQ-010 A handshake SHALL transfer on a rising edge where valid and ready are both 1.
- Shadow query buffer: sh_reg, sh_cnt, sh_full.
REQ-011 q_ready_out SHALL equal !sh_full.
- Query beat: writes q_base_in to sh_reg slot sh_cnt, then increments sh_cnt.
REQ-012 sh_full SHALL set on a query beat with q_last_in=1, or on the beat that makes sh_cnt equal NUM_PES.
- Slots not written before sh_full SHALL read 2'b00.
REQ-013 Commit SHALL copy sh_reg to S_out and sh_cnt to q_len_out on the same edge, then clear sh_reg, sh_cnt and sh_full.
REQ-014 A hold counter SHALL load NUM_PES-1 on commit and decrement to 0 once per cycle.
- While the hold counter is nonzero, S_out SHALL NOT change.
- Purpose: store_S ripples one PE per cycle.
REQ-015 Target FSM states: IDLE, STREAM, BUBBLE.
REQ-016 In IDLE, t_ready_out SHALL be 1 iff one of:
- (a) sh_full=1 and hold counter=0, or
- (b) sh_full=0 and a query has been committed since reset.
REQ-017 An IDLE target beat SHALL drive, registered on that edge:
- T_out=t_base_in, init_out=1;
- store_S_out=1 and commit, only when sh_full=1; otherwise store_S_out=0 and S_out unchanged.
- Next state: STREAM, or BUBBLE if t_last_in=1.
REQ-018 In STREAM, t_ready_out SHALL be 1.
- Each beat: T_out=t_base_in, init_out=0, store_S_out=0.
- Beat with t_last_in=1: next state BUBBLE.
REQ-019 In STREAM with t_valid_in=0:
- set underrun_err_out;
- drive T_out=0, init_out=0, store_S_out=0;
- remain in STREAM.
REQ-020 BUBBLE SHALL last exactly one cycle, then go to IDLE.
- t_ready_out=0, T_out=0, init_out=0, store_S_out=0.
- The array is therefore given exactly one bubble between targets.
REQ-021 In every cycle without a target beat, T_out, init_out and store_S_out SHALL be 0.
REQ-022 Target-to-array latency SHALL be exactly 1 cycle.
REQ-023 Query loading SHALL proceed concurrently with target streaming. A query beat and a commit on the same edge:
- the commit takes the pre-edge shadow contents;
- the shadow is cleared;
- the new beat lands in slot 0 with sh_cnt=1.
- This case cannot arise, because q_ready_out=0 whenever sh_full=1.
REQ-024 q_last_in on a beat with sh_cnt=NUM_PES-1 SHALL be legal; sh_full sets once.
REQ-025 t_ready_out and q_ready_out SHALL be combinational from state only, never from the valid inputs.

Reset
REQ-026 On rst=1 at a rising edge, all of the following SHALL clear, with rst overriding any simultaneous handshake:
- state to IDLE;
- sh_reg, sh_cnt, sh_full, S_out, q_len_out to 0;
- hold counter to 0;
- T_out, init_out, store_S_out, underrun_err_out to 0;
- the committed-since-reset flag to 0.
REQ-027 Reset during STREAM SHALL abandon the target with no bubble.
- After reset, t_ready_out=0 until a new query is full.

Verification (NUM_PES=4)
REQ-028 Load query 1,2,3,0 (last on 4th), then target 2,1 (last on 2nd):
- q_ready falls after the 4th beat;
- next cycle: T_out=2, init=1, store_S=1, S_out=8'b00111001, q_len=4;
- then T_out=1, init=0, store_S=0;
- then one bubble cycle.
REQ-029 Short query 3,3 (last on 2nd): S_out=8'b00001111, q_len_out=2.
REQ-030 Two back-to-back targets on one query:
- second target: init=1, store_S=0, S_out unchanged;
- exactly one zero cycle between the last T of the first target and the first T of the second.
REQ-031 New query full while the hold counter is nonzero:
- t_ready_out stays 0 until the hold counter reaches 0;
- then the commit occurs with store_S=1.
REQ-032 Drop t_valid_in for one cycle mid-target:
- underrun_err_out=1 and stays 1;
- T_out=0 that cycle;
- the stream resumes on the next beat.
REQ-033 Assert rst during STREAM:
- next cycle all outputs are 0 and state is IDLE;
- t_ready_out=0 and q_ready_out=1.
